vga_ctrl_apb: RTL and testbench
===============================

// Module: vga_ctrl_apb
// PURPOSE
//  Parametrised APB3 VGA controller: programmable-timing raster generator, double-buffered framebuffer,
//  CSR block. Framebuffer writes go to the back buffer, scan-out reads the front buffer, and the swap
//  is vsync-aligned so there is no tearing. Sits on the SoC APB fabric as a peripheral; drives the board VGA pins.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line;   H_FP 16; H_SYNC 96; H_BP 48  horizontal porch/sync, in pixels
//  V_ACTIVE 480 visible lines/frame;   V_FP 10; V_SYNC 2;  V_BP 33  vertical porch/sync, in lines
//  FB_AW    19  word-address width of one buffer; depth is 2**FB_AW; requires 2**FB_AW >= H_ACTIVE*V_ACTIVE
// PORTS
//  clock       in   1   single clock, shared by APB and pixel logic
//  reset       in   1   synchronous, active-high
//  in_paddr    in  32   APB address; [23]=0 framebuffer, [23]=1 CSR
//  in_psel/in_penable/in_pwrite  in 1 each   APB3 control
//  in_pprot    in   3   ignored
//  in_pwdata   in  32   write data; a pixel is 0x00RRGGBB
//  in_pstrb    in   4   byte strobes, honoured on framebuffer writes
//  in_pready   out  1   access-phase completion
//  in_prdata   out 32   read data
//  in_pslverr  out  1   error response
//  vga_r/g/b   out  8   pixel colour, 0 outside the active area
//  vga_hsync   out  1   active-low horizontal sync
//  vga_vsync   out  1   active-low vertical sync
//  vga_valid   out  1   pixel in active area
// BEHAVIOUR
//  APB: in_pready=1 in every access cycle (psel&penable), so there are no wait states. Setup-phase writes have no effect.
//  FB write: word in_paddr[FB_AW+1:2] of the back buffer (!front), byte-merged per in_pstrb.
//  FB read: in_prdata=0, in_pslverr=1. The FB is write-only from APB.
//  CSR offsets, in_paddr[3:2]:
//   0 CTRL RW:   [0] enable; [1] swap request, write-1-sets pending, reads 0
//   1 STATUS RO: [0] front index; [1] swap pending; [2] in vblank
//   2 FRAME RO:  32-bit completed-frame count, wraps at 2**32
//   3 IRQ:       see CONFIGURATION
//  Writes to read-only CSRs are ignored and return no error.
//  Timing: H_TOTAL = sum of the H params, V_TOTAL = sum of the V params.
//   hcnt counts 0..H_TOTAL-1. vcnt increments when hcnt wraps and counts 0..V_TOTAL-1.
//   Active area: hcnt<H_ACTIVE && vcnt<V_ACTIVE.
//   hsync low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync low for vcnt in the equivalent V window.
//  Scan-out: a pixel address counter resets to 0 at frame start and increments per active pixel.
//   The RAM read is synchronous, so every vga_* output is registered one cycle after its counter state.
//   Latency from counter to pins = 1 clock.
//  Enable=0: counters, address and outputs are held at reset values. Going 0->1 starts at (0,0) next cycle.
//   Clearing enable mid-frame returns to reset values on the next cycle.
//  Frame end = (hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1 && enable). On frame end:
//   FRAME increments; if swap pending, front toggles and pending clears.
//   A swap-request write in the same cycle as frame end sets pending and is not consumed until the next frame end.
//  Reset values: vga_r/g/b=0, vga_valid=0, vga_hsync=1, vga_vsync=1, in_prdata=0, in_pslverr=0,
//   front=0, pending=0, enable=0, FRAME=0. FB contents are not reset.
// CONFIGURATION
//  VGA_FRAME_IRQ_EN defined:
//   extra output irq (1 bit, reset 0). IRQ CSR: [0] frame-done flag, write-1-to-clear; [1] irq mask, RW.
//   The flag is set at frame end; set wins over a same-cycle clear. irq = flag & mask.
//  VGA_FRAME_IRQ_EN undefined: no irq port; IRQ CSR reads 0, and writes to it are ignored.
// STRUCTURE
//  Package vga_pkg: CSR offset constants, CTRL/STATUS/IRQ bit indices, default timing constants.
//  Sub-module vga_timing_gen: hcnt/vcnt, active, sync, frame-end and vblank; parametrised by the H_*/V_* params.
//  The top holds the APB decode, the CSRs, the 2x(2**FB_AW)x32 RAM and the output pipeline register.
// TESTING (small timing params, e.g. H 4/1/1/1, V 3/1/1/1, FB_AW 4)
//  1 Reset, then idle -> all outputs at reset values; CTRL reads 0; FRAME reads 0.
//  2 Write 0x00112233 to FB word 0, then CTRL=1 -> first active pixel r=0x11 g=0x22 b=0x33,
//    1 clock after hcnt=vcnt=0; hsync/vsync low exactly in the programmed windows.
//  3 Swap request mid-frame -> STATUS pending=1; front toggles only at frame end; data written to the back buffer
//    appears on the pins the following frame. Also cover a swap write on the frame-end cycle -> swap delayed one frame.
//  4 FB read -> in_pslverr=1, in_prdata=0. Write with pstrb=4'b0010 -> only byte [15:8] changes.
//  5 Clear enable mid-frame -> next cycle outputs blank, syncs high; re-enable -> restarts at (0,0).
//  6 VGA_FRAME_IRQ_EN: mask=1 -> irq rises at frame end; W1C drops it; clear coinciding with frame end leaves it set.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the APB VGA controller: CSR map, CSR bit positions, default 640x480 timing.
package vga_pkg;

    typedef enum logic [1:0] {
        CSR_CTRL   = 2'd0,
        CSR_STATUS = 2'd1,
        CSR_FRAME  = 2'd2,
        CSR_IRQ    = 2'd3
    } csr_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_SWAP   = 1;
    localparam int STAT_FRONT  = 0;
    localparam int STAT_PEND   = 1;
    localparam int STAT_VBLANK = 2;
    localparam int IRQ_FLAG    = 0;
    localparam int IRQ_MASK    = 1;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_FB_AW    = 19;

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and the combinational timing flags derived from them.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    output logic active_o,
    output logic hsync_n_o,
    output logic vsync_n_o,
    output logic frame_end_o,
    output logic vblank_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          h_last, v_last;

    assign h_last = (hcnt_q == HW'(H_TOTAL - 1));
    assign v_last = (vcnt_q == VW'(V_TOTAL - 1));

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (!en_i) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Compared as int so a zero back porch cannot overflow the counter width.
    assign active_o    = en_i && (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
    assign hsync_n_o   = !((int'(hcnt_q) >= H_ACTIVE + H_FP) &&
                           (int'(hcnt_q) <  H_ACTIVE + H_FP + H_SYNC));
    assign vsync_n_o   = !((int'(vcnt_q) >= V_ACTIVE + V_FP) &&
                           (int'(vcnt_q) <  V_ACTIVE + V_FP + V_SYNC));
    assign frame_end_o = en_i && h_last && v_last;
    assign vblank_o    = en_i && (int'(vcnt_q) >= V_ACTIVE);

endmodule

// File: rtl/vga_ctrl_apb.sv
// APB3 VGA controller top: APB decode, CSRs, double-buffered framebuffer and scan-out register.
// Define VGA_FRAME_IRQ_EN to add the frame-done interrupt output and the live IRQ CSR.
module vga_ctrl_apb
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int FB_AW    = DEF_FB_AW
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic        in_pwrite,
    input  logic [2:0]  in_pprot,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_valid
`ifdef VGA_FRAME_IRQ_EN
    ,
    output logic        irq
`endif
);

    logic        acc, wr_acc, rd_acc, csr_sel, fb_wr, csr_wr, swap_wr;
    csr_e        csr;
    logic        tg_active, tg_hsync_n, tg_vsync_n, frame_end, vblank;
    logic        enable_q, enable_d, front_q, front_d, pending_q, pending_d;
    logic [31:0] frame_q, frame_d;
    logic [FB_AW-1:0] addr_q, addr_d;
    logic        act_q, hs_q, vs_q;
    logic [31:0] rd_q;
    logic [31:0] mem [2**(FB_AW+1)];
    logic        unused;

    assign acc     = in_psel & in_penable;
    assign wr_acc  = acc & in_pwrite;
    assign rd_acc  = acc & ~in_pwrite;
    assign csr_sel = in_paddr[23];
    assign csr     = csr_e'(in_paddr[3:2]);
    assign fb_wr   = wr_acc & ~csr_sel;
    assign csr_wr  = wr_acc & csr_sel;
    assign swap_wr = csr_wr && (csr == CSR_CTRL) && in_pwdata[CTRL_SWAP];
    assign unused  = ^{in_pprot, in_paddr, rd_q[31:24]};

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clock      (clock),
        .reset      (reset),
        .en_i       (enable_q),
        .active_o   (tg_active),
        .hsync_n_o  (tg_hsync_n),
        .vsync_n_o  (tg_vsync_n),
        .frame_end_o(frame_end),
        .vblank_o   (vblank)
    );

    // A swap request landing on frame end is kept for the following frame end.
    always_comb begin
        enable_d  = enable_q;
        front_d   = front_q;
        pending_d = pending_q;
        frame_d   = frame_q;
        addr_d    = addr_q;
        if (csr_wr && (csr == CSR_CTRL)) enable_d = in_pwdata[CTRL_EN];
        if (frame_end) begin
            frame_d = frame_q + 32'd1;
            if (pending_q) begin
                front_d   = ~front_q;
                pending_d = 1'b0;
            end
        end
        if (swap_wr) pending_d = 1'b1;
        if (!enable_q || frame_end) addr_d = '0;
        else if (tg_active)         addr_d = addr_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enable_q  <= 1'b0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            frame_q   <= '0;
            addr_q    <= '0;
            act_q     <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            enable_q  <= enable_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            frame_q   <= frame_d;
            addr_q    <= addr_d;
            act_q     <= tg_active;
            hs_q      <= tg_hsync_n | ~enable_q;
            vs_q      <= tg_vsync_n | ~enable_q;
        end
    end

    always_ff @(posedge clock) begin
        if (fb_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (in_pstrb[i]) mem[{~front_q, in_paddr[FB_AW+1:2]}][8*i +: 8] <= in_pwdata[8*i +: 8];
            end
        end
        rd_q <= mem[{front_q, addr_q}];
    end

    assign vga_r     = act_q ? rd_q[23:16] : 8'h00;
    assign vga_g     = act_q ? rd_q[15:8]  : 8'h00;
    assign vga_b     = act_q ? rd_q[7:0]   : 8'h00;
    assign vga_valid = act_q;
    assign vga_hsync = hs_q;
    assign vga_vsync = vs_q;

`ifdef VGA_FRAME_IRQ_EN
    logic flag_q, flag_d, mask_q, mask_d;

    always_comb begin
        flag_d = flag_q;
        mask_d = mask_q;
        if (csr_wr && (csr == CSR_IRQ)) begin
            if (in_pwdata[IRQ_FLAG]) flag_d = 1'b0;
            mask_d = in_pwdata[IRQ_MASK];
        end
        if (frame_end) flag_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flag_q <= 1'b0;
            mask_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
            mask_q <= mask_d;
        end
    end

    assign irq = flag_q & mask_q;
`endif

    assign in_pready  = 1'b1;
    assign in_pslverr = rd_acc & ~csr_sel;

    always_comb begin
        in_prdata = '0;
        if (rd_acc && csr_sel) begin
            case (csr)
                CSR_CTRL:   in_prdata[CTRL_EN] = enable_q;
                CSR_STATUS: begin
                    in_prdata[STAT_FRONT]  = front_q;
                    in_prdata[STAT_PEND]   = pending_q;
                    in_prdata[STAT_VBLANK] = vblank;
                end
                CSR_FRAME:  in_prdata = frame_q;
`ifdef VGA_FRAME_IRQ_EN
                CSR_IRQ: begin
                    in_prdata[IRQ_FLAG] = flag_q;
                    in_prdata[IRQ_MASK] = mask_q;
                end
`endif
                default: in_prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_ctrl_apb.sv
// Randomized scoreboard bench for vga_ctrl_apb with a frame-position reference model.
module tb_vga_ctrl_apb;

    localparam int HA = 4, HFP = 1, HSY = 1, HBP = 1;
    localparam int VA = 3, VFP = 1, VSY = 1, VBP = 1;
    localparam int AW = 4;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int NPIX = HT * VT;
    localparam logic [31:0] CSR_BASE = 32'h0080_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]  pprot = '0;
    logic [3:0]  pstrb = '0;
    logic        pready, pslverr, hs, vs, valid;
    logic [31:0] prdata;
    logic [7:0]  r, g, b;
    logic        irq_w;

    vga_ctrl_apb #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .FB_AW(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_paddr(paddr), .in_psel(psel), .in_penable(penable), .in_pwrite(pwrite),
        .in_pprot(pprot), .in_pwdata(pwdata), .in_pstrb(pstrb),
        .in_pready(pready), .in_prdata(prdata), .in_pslverr(pslverr),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .vga_hsync(hs), .vga_vsync(vs), .vga_valid(valid)
`ifdef VGA_FRAME_IRQ_EN
        , .irq(irq_w)
`endif
    );
`ifndef VGA_FRAME_IRQ_EN
    assign irq_w = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       valid, hs, vs, irq, known;
    } pin_t;

    localparam pin_t PIN_RST = '{r: 8'h0, g: 8'h0, b: 8'h0, valid: 1'b0, hs: 1'b1,
                                 vs: 1'b1, irq: 1'b0, known: 1'b1};

    rsp_t rsp_q[$];
    pin_t pin_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state: position is a linear index into the frame, buffers are plain arrays.
    bit          m_en = 0, m_front = 0, m_pend = 0, m_flag = 0, m_mask = 0;
    int          m_k = 0;
    int unsigned m_frame = 0;
    logic [31:0] fbm [2][16];
    bit          fbk [2][16];
    pin_t        m_pins = PIN_RST;

    task automatic model_step();
        pin_t p;
        rsp_t rs;
        int h, v, idx, bk;
        bit fe, new_en, swapw;
        p = m_pins;
        p.irq = m_flag & m_mask;
        pin_q.push_back(p);
        if (psel && penable && !pwrite) begin
            rs = '{data: 32'h0, err: 1'b0};
            if (!paddr[23]) rs.err = 1'b1;
            else case (paddr[3:2])
                2'd0: rs.data = {31'h0, m_en};
                2'd1: rs.data = {29'h0, m_en && (m_k / HT) >= VA, m_pend, m_front};
                2'd2: rs.data = m_frame;
`ifdef VGA_FRAME_IRQ_EN
                2'd3: rs.data = {30'h0, m_mask, m_flag};
`endif
                default: rs.data = 32'h0;
            endcase
            rsp_q.push_back(rs);
        end
        if (reset) begin
            m_en = 0; m_k = 0; m_front = 0; m_pend = 0; m_frame = 0; m_flag = 0; m_mask = 0;
            m_pins = PIN_RST;
            return;
        end
        m_pins = PIN_RST;
        if (m_en) begin
            h = m_k % HT;
            v = m_k / HT;
            m_pins.valid = (h < HA) && (v < VA);
            m_pins.hs = !(h >= HA + HFP && h < HA + HFP + HSY);
            m_pins.vs = !(v >= VA + VFP && v < VA + VFP + VSY);
            if (m_pins.valid) begin
                idx = v * HA + h;
                {m_pins.r, m_pins.g, m_pins.b} = fbm[m_front][idx][23:0];
                m_pins.known = fbk[m_front][idx];
            end
        end
        fe = m_en && (m_k == NPIX - 1);
        new_en = m_en;
        swapw = 0;
        if (psel && penable && pwrite) begin
            if (!paddr[23]) begin
                idx = int'(paddr[AW+1:2]);
                bk = m_front ? 0 : 1;
                for (int i = 0; i < 4; i++)
                    if (pstrb[i]) fbm[bk][idx][8*i +: 8] = pwdata[8*i +: 8];
                if (pstrb == 4'hF) fbk[bk][idx] = 1;
            end else if (paddr[3:2] == 2'd0) begin
                new_en = pwdata[0];
                swapw = pwdata[1];
            end
`ifdef VGA_FRAME_IRQ_EN
            else if (paddr[3:2] == 2'd3) begin
                m_mask = pwdata[1];
                if (pwdata[0]) m_flag = 0;
            end
`endif
        end
        if (fe) begin
            m_frame++;
`ifdef VGA_FRAME_IRQ_EN
            m_flag = 1;
`endif
            if (m_pend) begin m_front = !m_front; m_pend = 0; end
        end
        if (swapw) m_pend = 1;
        m_k = m_en ? (m_k + 1) % NPIX : 0;
        m_en = new_en;
    endtask

    task automatic check_cycle();
        pin_t e, a;
        rsp_t x;
        a = '{r: r, g: g, b: b, valid: valid, hs: hs, vs: vs, irq: irq_w, known: 1'b1};
        tests++;
        if (pin_q.size() == 0) begin
            fails++;
            $display("FAIL pins: no expected entry at t=%0t", $time);
        end else begin
            e = pin_q.pop_front();
            if (a.valid !== e.valid || a.hs !== e.hs || a.vs !== e.vs || a.irq !== e.irq ||
                (e.known && {a.r, a.g, a.b} !== {e.r, e.g, e.b})) begin
                fails++;
                $display("FAIL pins t=%0t got rgb=%h v=%b hs=%b vs=%b irq=%b want rgb=%h v=%b hs=%b vs=%b irq=%b",
                         $time, {a.r, a.g, a.b}, a.valid, a.hs, a.vs, a.irq,
                         {e.r, e.g, e.b}, e.valid, e.hs, e.vs, e.irq);
            end
        end
        tests++;
        if (psel && penable) begin
            if (pready !== 1'b1) begin
                fails++;
                $display("FAIL pready t=%0t got %b want 1", $time, pready);
            end
            if (!pwrite) begin
                tests++;
                if (rsp_q.size() == 0) begin
                    fails++;
                    $display("FAIL apb_read: no expected entry at t=%0t", $time);
                end else begin
                    x = rsp_q.pop_front();
                    if (prdata !== x.data || pslverr !== x.err) begin
                        fails++;
                        $display("FAIL apb_read addr=%h t=%0t got %h/err=%b want %h/err=%b",
                                 paddr, $time, prdata, pslverr, x.data, x.err);
                    end
                end
            end
        end else if (prdata !== 32'h0 || pslverr !== 1'b0) begin
            fails++;
            $display("FAIL apb_idle t=%0t got %h/err=%b want 0/0", $time, prdata, pslverr);
        end
    endtask

    initial forever begin @(negedge clock); model_step(); end
    initial forever begin @(negedge clock); #1; check_cycle(); end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d; pstrb = s;
        @(posedge clock); #1 penable = 1;
        @(posedge clock); #1 psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clock); #1 penable = 1;
        @(posedge clock); #1 psel = 0; penable = 0;
    endtask

    function automatic logic [31:0] fba(input int w);
        return 32'(w) << 2;
    endfunction

    function automatic logic [31:0] csra(input int o);
        return CSR_BASE | (32'(o) << 2);
    endfunction

    // Returns one cycle ahead of the target so a following APB access lands on it.
    task automatic wait_pos(input int target);
        bit hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clock); #1;
            if (m_en && m_k == target) hit = 1;
        end
        if (!hit) begin
            tests++; fails++;
            $display("FAIL wait_pos target=%0d timed out", target);
        end
    endtask

    task automatic wait_front(input bit f);
        bit hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clock); #1;
            if (m_front == f) hit = 1;
        end
        if (!hit) begin
            tests++; fails++;
            $display("FAIL wait_front want=%0d timed out", f);
        end
    endtask

    initial begin
        idle(4);
        reset = 0;
        idle(2);
        apb_read(csra(0));
        apb_read(csra(2));
        apb_read(csra(1));
        apb_read(csra(3));
        apb_write(fba(0), 32'h0011_2233, 4'hF);
        for (int w = 1; w < HA * VA; w++) apb_write(fba(w), $urandom & 32'h00FF_FFFF, 4'hF);
        apb_read(fba(0));
        apb_write(fba(0), 32'hAABB_CCDD, 4'b0010);
        apb_write(csra(0), 32'h3, 4'hF);
        apb_read(csra(1));
        wait_front(1);
        for (int w = 0; w < HA * VA; w++) apb_write(fba(w), $urandom & 32'h00FF_FFFF, 4'hF);
        wait_pos(10);
        apb_write(csra(0), 32'h3, 4'hF);
        apb_read(csra(1));
        wait_front(0);
        wait_pos(NPIX - 2);
        apb_write(csra(0), 32'h3, 4'hF);
        apb_read(csra(1));
        wait_front(1);
        wait_pos(12);
        apb_write(csra(0), 32'h0, 4'hF);
        idle(3);
        apb_read(csra(1));
        apb_write(csra(0), 32'h1, 4'hF);
        idle(NPIX + 5);
        apb_write(csra(3), 32'h2, 4'hF);
        wait_pos(NPIX - 1);
        idle(2);
        apb_read(csra(3));
        apb_write(csra(3), 32'h3, 4'hF);
        apb_read(csra(3));
        wait_pos(NPIX - 2);
        apb_write(csra(3), 32'h3, 4'hF);
        apb_read(csra(3));
        apb_write(csra(1), 32'hFFFF_FFFF, 4'hF);
        apb_write(csra(2), 32'hFFFF_FFFF, 4'hF);
        apb_read(csra(2));
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 8))
                0, 1: apb_write(fba($urandom_range(0, 11)), $urandom & 32'h00FF_FFFF, 4'hF);
                2:    apb_write(fba($urandom_range(0, 15)), $urandom, 4'($urandom));
                3:    apb_read(csra($urandom_range(0, 3)));
                4:    apb_read(fba($urandom_range(0, 15)));
                5:    apb_write(csra(0), 32'h1 | (32'($urandom_range(0, 1)) << 1), 4'hF);
                6:    apb_write(csra(3), 32'($urandom_range(0, 3)), 4'hF);
                7:    idle($urandom_range(1, 5));
                default: apb_write(csra($urandom_range(1, 2)), $urandom, 4'hF);
            endcase
        end
        idle(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
